// File: rtl/pag_refill_if.sv
// Memory read handshake between the page-refill sequencer and the memory port.
// master = refill sequencer (issues the read), slave = memory side.
interface pag_refill_if #(
    parameter int PA_W   = 22,
    parameter int DATA_W = 36
);
    logic              mem_req;
    logic [PA_W-1:0]   mem_adr;
    logic              mem_ack;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_par_err;

    modport master (
        output mem_req,
        output mem_adr,
        input  mem_ack,
        input  mem_valid,
        input  mem_data,
        input  mem_par_err
    );

    modport slave (
        input  mem_req,
        input  mem_adr,
        output mem_ack,
        output mem_valid,
        output mem_data,
        output mem_par_err
    );
endinterface

// File: rtl/pag_refill.sv
// Page-refill sequencer: on a page-table miss, fetches the page-table word from the
// user/exec process table and writes it into the page table and directory.
module pag_refill #(
    parameter int TIMEOUT = 64,
    parameter int PA_W    = 22,
    parameter int BASE_W  = 13,
    parameter int DATA_W  = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              refill_req,
    input  logic              vma_user,
    input  logic [8:0]        vma_page,
    input  logic [BASE_W-1:0] ubr,
    input  logic [BASE_W-1:0] ebr,
    input  logic              abort,
    pag_refill_if.master      mem,
    output logic              pgrf_cyc,
    output logic              pgrf_sel,
    output logic [DATA_W-1:0] pt_in,
    output logic              pt_wr,
    output logic              pt_dir_wr,
    output logic              refill_done,
    output logic              refill_error
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PA_W-1:0]   adr;
    logic              capture;
    logic              req_c;
    logic [BASE_W-1:0] base;

    assign base        = vma_user ? ubr : ebr;
    assign mem.mem_req = req_c;
    assign mem.mem_adr = adr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The even/odd half of the page-table entry pair is selected by the page LSB;
    // the word address drops it and inserts a zero between base and page pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr      <= '0;
            pgrf_sel <= 1'b0;
            pt_in    <= '0;
            cnt      <= '0;
        end else begin
            if (state == IDLE && refill_req) begin
                adr      <= PA_W'({base, 1'b0, vma_page[8:1]});
                pgrf_sel <= vma_page[0];
            end
            if (capture) begin
                pt_in <= mem.mem_data;
            end
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_c        = 1'b0;
        pgrf_cyc     = 1'b0;
        pt_wr        = 1'b0;
        pt_dir_wr    = 1'b0;
        refill_done  = 1'b0;
        refill_error = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (refill_req) state_nxt = REQ;
            end
            REQ: begin
                req_c    = 1'b1;
                pgrf_cyc = 1'b1;
                if (abort)             state_nxt = IDLE;
                else if (mem.mem_ack)  state_nxt = WAIT;
            end
            WAIT: begin
                pgrf_cyc = 1'b1;
                // Data arriving on the last allowed cycle takes priority over timeout.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (mem.mem_valid && !mem.mem_par_err) begin
                    capture   = 1'b1;
                    state_nxt = WRITE;
                end else if (mem.mem_valid) begin
                    state_nxt = ERR;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = ERR;
                end
            end
            WRITE: begin
                pt_wr     = 1'b1;
                pt_dir_wr = 1'b1;
                pgrf_cyc  = 1'b1;
                state_nxt = abort ? IDLE : DONE;
            end
            DONE: begin
                refill_done = 1'b1;
                state_nxt   = IDLE;
            end
            ERR: begin
                refill_error = 1'b1;
                if (abort || !refill_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
